// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver FSM states. The RX_ prefix keeps the PARITY state distinct from
  // the PARITY parameter of uart_rx_os.
  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_BREAK_WAIT = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_tick_div(input int clockrate, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clockrate + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO: registered storage, combinational head, overrun flag.
// Latency: a push is visible at the head (empty deasserts) 1 cycle after the push cycle.
// Backpressure: a push into a full FIFO without a simultaneous pop is dropped and
//   overrun pulses for one cycle; a push and a pop together when full both take effect.
// Ports: clk, reset (sync, active-high), push_vld/push_dat (write side),
//   pop (consumer takes head), full, empty, head_dat (0 when empty), overrun.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overrun_q, overrun_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    do_push   = push_vld & (~full | do_pop);
    overrun_d = push_vld & full & ~do_pop;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun  = overrun_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with 3-sample majority vote, parity/frame/break flags.
// Latency: entry pushed at the mid-point decision of the last stop bit; valid 1 cycle later.
// Backpressure: valid/ready stream behind a FIFO_DEPTH FIFO; when full, new words are
//   dropped with a one-cycle rx_overrun pulse.
// Ports: clk, reset (sync, active-high), UART_RX (async line, idle high),
//   rx_data/rx_parity_error/rx_frame_error/rx_break (head entry), rx_data_valid,
//   rx_data_ready, rx_overrun; rx_state_debug[2:0] only when UART_RX_DEBUG_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCKRATE   = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   UART_RX,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   rx_parity_error,
  output logic                   rx_frame_error,
  output logic                   rx_break,
  output logic                   rx_overrun
`ifdef UART_RX_DEBUG_EN
  ,
  output logic [2:0]             rx_state_debug
`endif
);

  localparam int DIV     = uart_tick_div(CLOCKRATE, BAUD, OVERSAMPLE);
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW      = WORD_LENGTH + 3;
  localparam bit HAS_PAR = (PARITY != int'(PARITY_NONE));
  localparam bit PAR_ODD = (PARITY == int'(PARITY_ODD));

  rx_state_e              state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]             s_q, s_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic                   par_err_q, par_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   par_bit_q, par_bit_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;

  logic          rx_sync, tick, mid, bit_end, maj, frame_now, brk, push_vld, pop;
  logic [FW-1:0] push_dat, head_dat;
  logic          fifo_full, fifo_empty;

  assign rx_sync = sync2_q;
  assign tick    = (tick_cnt_q == TW'(DIV - 1));
  assign mid     = tick && (s_q == 4'd9);
  assign bit_end = tick && (s_q == 4'd15);
  // samp_q holds the s=7 and s=8 samples; the s=9 sample is the live rx_sync.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);

  always_comb begin
    sync1_d     = UART_RX;
    sync2_d     = sync1_q;
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    s_d         = tick ? s_q + 4'd1 : s_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    par_bit_d   = par_bit_q;
    frame_now   = frame_err_q;
    brk         = 1'b0;
    push_vld    = 1'b0;

    if (tick && s_q == 4'd7) samp_d[0] = rx_sync;
    if (tick && s_q == 4'd8) samp_d[1] = rx_sync;

    case (state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          // Restart the tick phase on the start edge so samples land mid-bit.
          state_d     = RX_START;
          tick_cnt_d  = '0;
          s_d         = '0;
          bit_cnt_d   = '0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
          par_bit_d   = 1'b0;
        end
      end
      RX_START: begin
        if (mid && maj)   state_d = RX_IDLE;   // glitch, not a start bit
        else if (bit_end) state_d = RX_DATA;
      end
      RX_DATA: begin
        if (mid) shift_d = {maj, shift_q[WORD_LENGTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == 4'(WORD_LENGTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (mid) begin
          par_bit_d = maj;
          par_err_d = (((^shift_q) ^ maj) != PAR_ODD);
        end
        if (bit_end) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (mid) begin
          frame_now   = frame_err_q | ~maj;
          frame_err_d = frame_now;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            // Push at the decision point so back-to-back frames are not missed.
            push_vld = 1'b1;
            brk      = frame_now & (shift_q == '0) & (~HAS_PAR | ~par_bit_q);
            state_d  = frame_now ? RX_BREAK_WAIT : RX_IDLE;
          end
        end
        if (bit_end) bit_cnt_d = bit_cnt_q + 4'd1;
      end
      RX_BREAK_WAIT: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      tick_cnt_q  <= '0;
      s_q         <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_bit_q   <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      s_q         <= s_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      par_bit_q   <= par_bit_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign push_dat = {brk, frame_now, par_err_q, shift_q};
  assign pop      = rx_data_valid & rx_data_ready;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat),
    .overrun  (rx_overrun)
  );

  assign rx_data_valid = ~fifo_empty;
  assign {rx_break, rx_frame_error, rx_parity_error, rx_data} = head_dat;

`ifdef UART_RX_DEBUG_EN
  assign rx_state_debug = state_q;
`endif

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver, the next generation of the team's `uart` RX path. It supports configurable word length, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote, and the block reports parity, framing and break errors. Received words are buffered in a small FIFO behind a valid/ready stream, so a stalled consumer loses nothing until the FIFO is full. It sits between the `UART_RX` pin and any stream consumer.

## Interface
- `CLOCKRATE`, 100000000: clk frequency in Hz.
- `BAUD`, 115200: line rate.
- `WORD_LENGTH`, 8: data bits, legal 5..9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal values 1 or 2.
- `OVERSAMPLE`, 16: ticks per bit, fixed at 16.
- `FIFO_DEPTH`, 4: power of two, ≥2.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `UART_RX`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  WORD_LENGTH  FIFO head data, LSB = first bit received.
- `rx_data_valid`  out  1  FIFO not empty.
- `rx_data_ready`  in  1  consumer accepts the head word.
- `rx_parity_error`  out  1  head entry's parity flag.
- `rx_frame_error`  out  1  head entry's stop-bit flag.
- `rx_break`  out  1  head entry's break flag.
- `rx_overrun`  out  1  one-cycle pulse when a word is dropped.

## Operation
**Sampling**
- `UART_RX` passes through a 2-flop synchroniser to `rx_sync`; both flops reset to 1.
- Tick divider DIV = round(CLOCKRATE/(BAUD·16)), which is 54 at the defaults. The tick counter counts 0..DIV-1 and asserts `tick` at DIV-1.
- The counter is cleared on leaving IDLE, so sample phase aligns to the start edge.
- Within each bit, sample counter `s` runs 0..15 on ticks. The bit value is the majority of samples taken at s = 7, 8, 9, decided at s = 9.

**States (enum in package)**
- IDLE: `rx_sync` == 0 → START.
- START: majority 1 → IDLE (false start). Majority 0 → DATA at next s = 0.
- DATA: WORD_LENGTH bits, shifted in LSB first. Then → PARITY if PARITY ≠ 0, else → STOP.
- PARITY: parity_error = (XOR of data bits ^ received bit) != (PARITY == 2 ? 1 : 0).
- STOP: STOP_BITS bits, each majority must be 1, otherwise frame_error = 1.
  - At the decision of the last stop bit, push {break, frame_error, parity_error, data} to the FIFO. Do not wait for the end of the bit.
  - Then go to IDLE if frame_error = 0, else BREAK_WAIT.
  - break = frame_error & (data == 0) & (parity bit == 0 when present).
- BREAK_WAIT: hold until `rx_sync` == 1, then → IDLE. No further entries are produced during a held-low line.

**FIFO**
- Push is accepted when not full.
- Pop occurs when `rx_data_valid & rx_data_ready`.
- Push when full and no simultaneous pop: the new word is dropped, FIFO contents are unchanged, and `rx_overrun` pulses for 1 cycle.
- Push and pop together when full: both occur, no overrun.
- Outputs are driven from the head entry (registered storage, combinational read). Order is preserved.

**Reset mid-operation**
- State → IDLE, FIFO emptied, partial word discarded.

## Timing
- Reset values:
  - `rx_data_valid` = 0.
  - `rx_overrun` = 0.
  - `rx_data` and error flags = 0 (empty-FIFO head is forced to 0).
  - State IDLE, counters 0, synchroniser 1.
- Edge-to-IDLE-exit latency: 2 cycles (synchroniser) + 1.
- `rx_data_valid` rises 1 cycle after the push cycle.
- Bit period = 16·DIV clocks, which is 864 at the defaults.
- `rx_data` and flags must be stable while `rx_data_valid & !rx_data_ready`.

## Configuration
- `UART_RX_DEBUG_EN` defined: adds output port `rx_state_debug` [2:0], the current state encoding from the package enum.
- `UART_RX_DEBUG_EN` not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_e` (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT).
  - `parity_e` (PARITY_NONE = 0, PARITY_EVEN = 1, PARITY_ODD = 2).
  - Function `uart_tick_div(clockrate, baud, oversample)`.
- Sub-module `uart_rx_fifo` is parametrised by WIDTH and DEPTH. It provides push, pop, full, empty and head, and implements the overrun rule.

## Test plan
All scenarios use the defaults unless stated; the bench bit-bangs 864 clocks per bit.
- 8N1 byte 0x5A → one entry, `rx_data` = 0x5A, all flags 0, valid asserted about 9.56 bit times after the start edge.
- PARITY = 1, byte 0xA5 sent with parity bit 1 → `rx_data` = 0xA5, `rx_parity_error` = 1. The same byte with parity bit 0 → error 0.
- Framing and break:
  - Byte 0x33 with stop bit 0 → `rx_frame_error` = 1, `rx_break` = 0.
  - Line held low for 20 bit times → exactly one entry: data 0x00, frame = 1, break = 1. The next byte 0x7E after the line returns high → 0x7E, clean.
- Glitch: 200-clock low pulse on idle line → no entry, state returns to IDLE.
- Overrun: `rx_data_ready` = 0, send 0x10..0x14 → `rx_overrun` pulses once, on the fifth word. With `rx_data_ready` = 1 the FIFO drains 0x10, 0x11, 0x12, 0x13 in order.
- Reset during DATA bit 3 → `rx_data_valid` = 0 next cycle, FIFO empty. A following byte 0x81 is received correctly.
